// File: rtl/vga_pkg.sv
// Shared types for the video line-fetch block: fetch FSM states and Wishbone constants.
package vga_pkg;
  typedef enum logic [1:0] {LF_IDLE, LF_FETCH, LF_FINISH, LF_ABORT} lf_state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hf;
endpackage

// File: rtl/line_ram.sv
// Two-bank line buffer: one write port into the back bank, one registered read port on the front bank.
module line_ram #(
  parameter int WORDS = 80,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  logic [31:0] mem [2][WORDS];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data <= '0;
    else       rd_data <= mem[rd_bank][rd_addr];
  end
endmodule

// File: rtl/vga_line_fetch.sv
// Pipelined Wishbone read master that prefetches one display line into the back bank
// of a double-buffered line RAM, then swaps banks; a watchdog aborts a stuck fetch.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int WORDS   = 80,
  parameter int TIMEOUT = 1024,
  localparam int CW = $clog2(WORDS + 1),
  localparam int AW = $clog2(WORDS),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start,
  input  logic [31:0]   base,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          error,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic [31:0]   wb_adr,
  output logic [3:0]    wb_sel,
  output logic          wb_we,
  input  logic [31:0]   wb_dat,
  input  logic          wb_ack,
  input  logic          wb_stall
);
  lf_state_t     state, state_nx;
  logic [29:0]   base_q;
  logic [CW-1:0] cnt_q, issued, acked, cnt_clamp;
  logic [TW-1:0] wd;
  logic          front;
  logic          ack_ok, wd_fire;
  logic          unused_base;

  assign unused_base = ^base[1:0];
  assign cnt_clamp   = (count > CW'(WORDS)) ? CW'(WORDS) : count;

  // Acks only count while fetching and only up to the requested length; late ones are dropped.
  assign ack_ok  = (state == LF_FETCH) && wb_ack && (acked < cnt_q);
  assign wd_fire = (state == LF_FETCH) && !ack_ok && (acked < issued) &&
                   ((wd + 1'b1) == TW'(TIMEOUT));

  always_comb begin
    state_nx = state;
    busy     = (state != LF_IDLE);
    done     = (state == LF_FINISH);
    wb_cyc   = (state == LF_FETCH);
    wb_stb   = (state == LF_FETCH) && (issued < cnt_q);
    wb_adr   = {base_q + 30'(issued), 2'b00};
    wb_sel   = WB_SEL_ALL;
    wb_we    = 1'b0;
    case (state)
      LF_IDLE: begin
        if (start) state_nx = (cnt_clamp == '0) ? LF_FINISH : LF_FETCH;
      end
      LF_FETCH: begin
        if (ack_ok && ((acked + 1'b1) == cnt_q)) state_nx = LF_FINISH;
        else if (wd_fire)                         state_nx = LF_ABORT;
      end
      default: state_nx = LF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= LF_IDLE;
      base_q <= '0;
      cnt_q  <= '0;
      issued <= '0;
      acked  <= '0;
      wd     <= '0;
      front  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == LF_IDLE && start) begin
        base_q <= base[31:2];
        cnt_q  <= cnt_clamp;
        issued <= '0;
        acked  <= '0;
        wd     <= '0;
        error  <= 1'b0;
      end
      if (state == LF_FETCH) begin
        if (wb_stb && !wb_stall) issued <= issued + 1'b1;
        if (ack_ok)              acked  <= acked + 1'b1;
        // Watchdog only runs while reads are outstanding and nothing comes back.
        if (ack_ok)               wd <= '0;
        else if (acked < issued)  wd <= wd + 1'b1;
      end
      if (state == LF_FINISH) front <= ~front;
      if (wd_fire)            error <= 1'b1;
    end
  end

  line_ram #(.WORDS(WORDS)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (ack_ok),
    .wr_bank (~front),
    .wr_addr (acked[AW-1:0]),
    .wr_data (wb_dat),
    .rd_bank (front),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a pipelined Wishbone slave returning dat = adr.
module tb_vga_line_fetch;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base  = '0;
  logic [6:0]  count = '0;
  logic        busy, done, error;
  logic [6:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat   = '0;
  logic        wb_ack   = 1'b0;
  logic        wb_stall = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_adr[$];
  int          q_due[$];
  logic [31:0] iss_log[$];
  int          cyc_n = 0, fcyc = 0, ack_dly = 0;
  int          n_ack = 0, n_done = 0, n_cyc = 0;
  bit          no_ack = 0, stall_en = 0;

  vga_line_fetch #(.WORDS(80), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .error(error), .rd_addr(rd_addr), .rd_data(rd_data),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_dat(wb_dat), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  always #5 clk_i = ~clk_i;

  // Slave: samples at the edge, drives ack/stall 1ns later; acks in order after ack_dly cycles.
  always @(posedge clk_i) begin
    cyc_n++;
    if (start && !busy) fcyc = 0;
    else                fcyc++;
    if (wb_cyc && wb_stb && !wb_stall) begin
      q_adr.push_back(wb_adr);
      q_due.push_back(cyc_n + ack_dly);
      iss_log.push_back(wb_adr);
    end
    if (wb_cyc && wb_ack) n_ack++;
    if (done) n_done++;
    if (wb_cyc) n_cyc++;
    #1;
    wb_ack = 1'b0;
    if (!no_ack && q_due.size() > 0 && q_due[0] <= cyc_n) begin
      wb_ack = 1'b1;
      wb_dat = q_adr.pop_front();
      void'(q_due.pop_front());
    end
    wb_stall = stall_en && fcyc >= 2 && fcyc <= 4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [31:0] b, input logic [6:0] c);
    base  = b;
    count = c;
    start = 1'b1;
    @(posedge clk_i); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = 0;
    while (!done && lat < max) begin
      @(posedge clk_i); #2;
      lat++;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] idx, input logic [31:0] exp);
    rd_addr = idx;
    @(posedge clk_i); #2;
    chk(tag, rd_data, exp);
  endtask

  task automatic adr_chk(input string tag, input logic [31:0] b, input int n);
    chk({tag, "_nreq"}, iss_log.size(), n);
    for (int i = 0; i < n && i < iss_log.size(); i++)
      chk($sformatf("%s_adr%0d", tag, i), iss_log[i], b + 32'(4 * i));
  endtask

  initial begin
    int lat, d0, a0, c0;
    bit stable;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_sel", wb_sel, 4'hf);
    chk("rst_rd", rd_data, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #2;

    // Zero-wait line of 4 words.
    iss_log.delete();
    go(32'h1000, 7'd4);
    chk("t1_busy", busy, 1);
    wait_done(40, lat);
    chk("t1_lat", lat, 5);
    adr_chk("t1", 32'h1000, 4);
    @(posedge clk_i); #2;
    chk("t1_busy_after", busy, 0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("t1_rd%0d", i), 7'(i), 32'h1000 + 32'(4 * i));

    // Stalls in cycles 2..4 and 3-cycle ack latency.
    iss_log.delete();
    stall_en = 1; ack_dly = 3;
    a0 = n_ack; d0 = n_done;
    go(32'h2000, 7'd4);
    wait_done(60, lat);
    chk("t2_done_seen", done, 1);
    @(posedge clk_i); #2;
    @(posedge clk_i); #2;
    stall_en = 0; ack_dly = 0;
    adr_chk("t2", 32'h2000, 4);
    chk("t2_acks", n_ack - a0, 4);
    chk("t2_dones", n_done - d0, 1);
    chk("t2_busy", busy, 0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("t2_rd%0d", i), 7'(i), 32'h2000 + 32'(4 * i));

    // Empty line: no bus cycle, immediate finish, banks swap.
    c0 = n_cyc;
    go(32'h9000, 7'd0);
    wait_done(10, lat);
    chk("t3_lat", lat, 0);
    @(posedge clk_i); #2;
    chk("t3_nocyc", n_cyc - c0, 0);
    rd_chk("t3_swap", 7'd0, 32'h1000);

    // Slave never acks: watchdog abort.
    no_ack = 1; d0 = n_done; lat = 0;
    go(32'h3000, 7'd4);
    while (!error && lat < 40) begin
      @(posedge clk_i); #2;
      lat++;
    end
    chk("t4_err_lat", lat, 17);
    chk("t4_cyc_abort", wb_cyc, 0);
    @(posedge clk_i); #2;
    @(posedge clk_i); #2;
    chk("t4_busy", busy, 0);
    chk("t4_nodone", n_done - d0, 0);
    chk("t4_err_sticky", error, 1);
    q_adr.delete(); q_due.delete();
    no_ack = 0;
    rd_chk("t4_front", 7'd0, 32'h1000);

    // Front bank stable during a fetch; start mid-fetch ignored.
    rd_addr = 7'd1;
    @(posedge clk_i); #2;
    iss_log.delete();
    go(32'h4000, 7'd3);
    chk("t5_err_clr", error, 0);
    stable = 1; lat = 0;
    while (!done && lat < 40) begin
      if (rd_data !== 32'h1004) stable = 0;
      if (lat == 1) begin
        base = 32'h5000; count = 7'd2; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk_i); #2;
      lat++;
    end
    start = 1'b0;
    chk("t5_lat", lat, 4);
    chk("t5_stable", stable, 1);
    chk("t5_rd_finish", rd_data, 32'h1004);
    @(posedge clk_i); #2;
    chk("t5_rd_after", rd_data, 32'h1004);
    @(posedge clk_i); #2;
    chk("t5_rd_new", rd_data, 32'h4004);
    adr_chk("t5", 32'h4000, 3);

    // Reset mid-fetch, then a clean fetch.
    go(32'h6000, 7'd8);
    repeat (3) begin @(posedge clk_i); #2; end
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    q_adr.delete(); q_due.delete();
    chk("t6_cyc", wb_cyc, 0);
    chk("t6_busy", busy, 0);
    chk("t6_error", error, 0);
    chk("t6_rd_rst", rd_data, 0);
    @(posedge clk_i); #2;
    rd_chk("t6_front0", 7'd0, 32'h4000);
    iss_log.delete();
    go(32'h7000, 7'd5);
    wait_done(40, lat);
    chk("t6_lat", lat, 6);
    @(posedge clk_i); #2;
    adr_chk("t6", 32'h7000, 5);
    rd_chk("t6_rd4", 7'd4, 32'h7010);
    rd_chk("t6_rd0", 7'd0, 32'h7000);

    // Count above WORDS clamps to 80.
    iss_log.delete();
    go(32'h8000, 7'd100);
    wait_done(200, lat);
    chk("t7_lat", lat, 81);
    @(posedge clk_i); #2;
    chk("t7_nreq", iss_log.size(), 80);
    rd_chk("t7_rd79", 7'd79, 32'h813C);

    // Word address wraps; low base bits ignored.
    iss_log.delete();
    go(32'hFFFF_FFFB, 7'd4);
    wait_done(40, lat);
    @(posedge clk_i); #2;
    chk("t8_nreq", iss_log.size(), 4);
    if (iss_log.size() == 4) begin
      chk("t8_adr0", iss_log[0], 32'hFFFF_FFF8);
      chk("t8_adr1", iss_log[1], 32'hFFFF_FFFC);
      chk("t8_adr2", iss_log[2], 32'h0000_0000);
      chk("t8_adr3", iss_log[3], 32'h0000_0004);
    end
    rd_chk("t8_rd1", 7'd1, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
